// File: rtl/morse_pkg.sv
// Shared Morse types and tables: FSM state enum, letter indices, gap lengths,
// and right-justified element patterns (1 = key down per unit) with lengths.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [4:0] LTR_A       = 5'd0;
    localparam logic [4:0] LTR_E       = 5'd4;
    localparam logic [4:0] LTR_Q       = 5'd16;
    localparam logic [4:0] LTR_Z       = 5'd25;
    localparam logic [4:0] NUM_LETTERS = 5'd26;

    localparam int GAP_UNITS      = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MAX_CODE_UNITS = 13;

    // Dot = 1, dash = 111, element separator = 0; stored right-justified.
    localparam logic [0:25][12:0] PAT_TABLE = '{
        13'b10111,         13'b111010101,     13'b11101011101,   13'b1110101,
        13'b1,             13'b101011101,     13'b111011101,     13'b1010101,
        13'b101,           13'b1011101110111, 13'b111010111,     13'b101110101,
        13'b1110111,       13'b11101,         13'b11101110111,   13'b10111011101,
        13'b1110111010111, 13'b1011101,       13'b10101,         13'b111,
        13'b1010111,       13'b101010111,     13'b101110111,     13'b11101010111,
        13'b1110101110111, 13'b11101110101
    };

    localparam logic [0:25][3:0] LEN_TABLE = '{
        4'd5,  4'd9,  4'd11, 4'd7,  4'd1,  4'd9,  4'd9,  4'd7,  4'd3,
        4'd13, 4'd9,  4'd9,  4'd7,  4'd5,  4'd11, 4'd11, 4'd13, 4'd7,
        4'd5,  4'd3,  4'd7,  4'd9,  4'd9,  4'd11, 4'd13, 4'd11
    };

endpackage

// File: rtl/morse_rom.sv
// Letter -> left-justified pattern, length, valid; purely combinational,
// zero latency, no flow control.
module morse_rom
    import morse_pkg::*;
#(
    parameter int CODE_W = 16
) (
    input  logic [4:0]        letter,
    output logic [CODE_W-1:0] pattern,
    output logic [3:0]        len,
    output logic              valid
);

    localparam int SH_W = $clog2(CODE_W + 1);

    logic [4:0]      idx;
    logic [SH_W-1:0] shamt;

    always_comb begin
        valid   = (letter < NUM_LETTERS);
        idx     = valid ? letter : LTR_A;
        len     = valid ? LEN_TABLE[idx] : 4'd0;
        shamt   = SH_W'(CODE_W) - SH_W'(len);
        pattern = valid ? (CODE_W'(PAT_TABLE[idx]) << shamt) : '0;
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse letter keyer: pattern MSB on DotDashOut the cycle after an accepted Start;
// Start is ignored while Busy. Optional MORSE_REPEAT_EN adds Repeat (word-gap loop).
module morse_encoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 250,
    parameter int CODE_W   = 16
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Start,
    input  logic [4:0] Letter,
`ifdef MORSE_REPEAT_EN
    input  logic       Repeat,
`endif
    output logic       DotDashOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_UNITS - 1);
`ifdef MORSE_REPEAT_EN
    localparam logic [3:0]       WORD_GAP_LAST = 4'(WORD_GAP_UNITS - 1);
`endif

    state_t            state,   state_nxt;
    logic [CODE_W-1:0] pattern, pattern_nxt;
    logic [DIV_W-1:0]  div,     div_nxt;
    logic [3:0]        cnt,     cnt_nxt;
    logic [3:0]        len,     len_nxt;
    logic              dotdash, dotdash_nxt;
    logic              done_nxt;
    logic              error_nxt;
    logic              tick;
`ifdef MORSE_REPEAT_EN
    logic [CODE_W-1:0] saved,   saved_nxt;
`endif

    logic [CODE_W-1:0] rom_pattern;
    logic [3:0]        rom_len;
    logic              rom_valid;

    morse_rom #(.CODE_W(CODE_W)) u_rom (
        .letter  (Letter),
        .pattern (rom_pattern),
        .len     (rom_len),
        .valid   (rom_valid)
    );

    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        div_nxt     = div;
        cnt_nxt     = cnt;
        len_nxt     = len;
        dotdash_nxt = 1'b0;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
`ifdef MORSE_REPEAT_EN
        saved_nxt   = saved;
`endif
        tick        = (div == DIV_LAST);

        case (state)
            IDLE: begin
                div_nxt = '0;
                cnt_nxt = '0;
                if (Start) begin
                    if (rom_valid) begin
                        state_nxt   = SEND;
                        pattern_nxt = rom_pattern;
                        len_nxt     = rom_len;
                        dotdash_nxt = rom_pattern[CODE_W-1];
`ifdef MORSE_REPEAT_EN
                        saved_nxt   = rom_pattern;
`endif
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end

            SEND: begin
                div_nxt     = tick ? '0 : div + DIV_W'(1);
                dotdash_nxt = dotdash;
                if (tick) begin
                    // Zero-fill shift: the key level for the next unit is the bit below MSB.
                    pattern_nxt = pattern << 1;
                    if (cnt == len - 4'd1) begin
                        state_nxt   = GAP;
                        cnt_nxt     = '0;
                        dotdash_nxt = 1'b0;
                    end else begin
                        cnt_nxt     = cnt + 4'd1;
                        dotdash_nxt = pattern[CODE_W-2];
                    end
                end
            end

            GAP: begin
                div_nxt = tick ? '0 : div + DIV_W'(1);
                if (tick) begin
                    if (cnt == GAP_LAST) begin
                        done_nxt = 1'b1;
`ifdef MORSE_REPEAT_EN
                        if (Repeat) begin
                            cnt_nxt = cnt + 4'd1;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (cnt == WORD_GAP_LAST) begin
                        state_nxt   = SEND;
                        pattern_nxt = saved;
                        dotdash_nxt = saved[CODE_W-1];
                        cnt_nxt     = '0;
`else
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            state   <= IDLE;
            pattern <= '0;
            div     <= '0;
            cnt     <= '0;
            len     <= '0;
            dotdash <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
`ifdef MORSE_REPEAT_EN
            saved   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pattern <= pattern_nxt;
            div     <= div_nxt;
            cnt     <= cnt_nxt;
            len     <= len_nxt;
            dotdash <= dotdash_nxt;
            Done    <= done_nxt;
            Error   <= error_nxt;
`ifdef MORSE_REPEAT_EN
            saved   <= saved_nxt;
`endif
        end
    end

    assign DotDashOut = dotdash;
    assign Busy       = (state != IDLE);

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 SHALL have parameter: TICK_DIV, 250, ClockIn cycles per Morse unit (>=2).
REQ-002 SHALL have parameter: CODE_W, 16, pattern register width in units (>=13).
REQ-003 SHALL have port: ClockIn  input  1  rising-edge clock.
REQ-004 SHALL have port: Resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: Start  input  1  request to send Letter, sampled each edge.
REQ-006 SHALL have port: Letter  input  5  0=A .. 25=Z; 26..31 invalid.
REQ-007 SHALL have port: DotDashOut  output  1  registered Morse signal, high = key down.
REQ-008 SHALL have port: Busy  output  1  high from accepted Start until return to IDLE.
REQ-009 SHALL have port: Done  output  1  one-cycle pulse on letter completion.
REQ-010 SHALL have port: Error  output  1  one-cycle pulse when Start carries invalid Letter.

Function
REQ-011 SHALL encode dot = 1 unit high, dash = 3 units high, 1 unit low between elements, 3 units low after last element.
REQ-012 SHALL store each letter left-justified in CODE_W bits with 4-bit length (A = 10111/5, E = 1/1, Q = 1110111010111/13).
REQ-013 SHALL use FSM states IDLE, SEND, GAP; IDLE->SEND on valid Start, SEND->GAP after length units, GAP->IDLE after 3 units.
REQ-014 SHALL accept Start only in IDLE; Start while Busy SHALL be ignored with no Error.
REQ-015 SHALL on accepted Start restart the unit divider so DotDashOut shows pattern MSB starting the cycle after Start, each unit exactly TICK_DIV cycles.
REQ-016 SHALL shift the pattern left one bit per unit tick, filling with 0; no rotation.
REQ-017 SHALL assert Done for one cycle on the GAP->IDLE cycle; Busy falls the same cycle.
REQ-018 SHALL, on Start in IDLE with Letter >= 26, pulse Error one cycle after Start, remain IDLE, keep DotDashOut low.
REQ-019 SHALL run the divider only while Busy; divider width = clog2(TICK_DIV).
REQ-020 SHALL hold DotDashOut low in IDLE and GAP.

Reset
REQ-021 SHALL on Resetn low at an edge set state IDLE, DotDashOut 0, Busy 0, Done 0, Error 0, divider 0, pattern 0.
REQ-022 SHALL abort any transmission mid-letter on reset with no Done pulse.
REQ-023 SHALL give reset priority over Start on the same edge.

Configuration
REQ-024 SHALL, with MORSE_REPEAT_EN defined, add input Repeat (1 bit); if Repeat high when GAP ends, reload same letter and re-enter SEND after 4 further low units (7-unit word gap), Done still pulsing per letter, Busy staying high.
REQ-025 SHALL, without MORSE_REPEAT_EN, omit Repeat port and always return to IDLE after GAP.

Structure
REQ-026 SHALL place state enum, letter index constants, 26-entry pattern/length table and GAP_UNITS=3, WORD_GAP_UNITS=7 in shared package morse_pkg.
REQ-027 SHALL implement table lookup in sub-module morse_rom (combinational, Letter -> pattern, length, valid).

Verification (TICK_DIV=4)
REQ-028 SHALL check Start, Letter=0 (A) -> DotDashOut 1 for 4 cycles, 0 for 4, 1 for 12, then 0 for 12; Done at cycle 32 after Start.
REQ-029 SHALL check Letter=4 (E) -> high 4 cycles, low 12, Done; Busy high for exactly 16 cycles.
REQ-030 SHALL check Letter=30 -> Error pulse one cycle, Busy 0, DotDashOut 0 throughout.
REQ-031 SHALL check Start with Letter=1 asserted 10 cycles into A -> ignored; output matches REQ-028 exactly.
REQ-032 SHALL check Resetn low 6 cycles into Letter=16 (Q) -> next cycle DotDashOut 0, Busy 0, no Done.
REQ-033 SHALL check with MORSE_REPEAT_EN, Repeat=1, Letter=4 -> pattern high 4, low 28, high 4, Done every 32 cycles.
